// File: rtl/pcm_receiver.sv
// ---------------------------------------------------------------------------
// PcmReceiver: takes received Ethernet frames carrying 16-channel, 16-bit PCM
// audio and stores the payload into one of two pages. At each frame-rate
// strobe it plays one 16-sample audio frame back out.
//
// Ports
//   clk          system clock, all logic on the rising edge
//   rst_n        asynchronous active-low reset
//   rx_sof       one-cycle pulse at the start of a received frame
//   rx_valid     rx_data carries a byte this cycle
//   rx_data      received byte, destination MAC first
//   rx_eof       one-cycle pulse after the last byte, qualifies rx_crc_ok
//   rx_crc_ok    frame check sequence good
//   au_stb_pcm   one-cycle audio frame-rate strobe
//   pcm_valid    pcm_chan / pcm_data carry a sample
//   pcm_chan     channel index of the current sample
//   pcm_data     signed sample, zero when no packet data is available
//   drop         one-cycle pulse, packet discarded
//   underrun     one-cycle pulse, frame played without data
// ---------------------------------------------------------------------------
module pcm_receiver #(
    parameter int unsigned HDR_LEN    = 14,
    parameter logic [15:0] ETHERTYPE  = 16'h88B5,
    parameter bit          CHECK_TYPE = 1'b1,
    parameter int unsigned NFRAMES    = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx_sof,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    input  logic        rx_eof,
    input  logic        rx_crc_ok,
    input  logic        au_stb_pcm,
    output logic        pcm_valid,
    output logic [3:0]  pcm_chan,
    output logic [15:0] pcm_data,
    output logic        drop,
    output logic        underrun
);

    localparam int unsigned NW  = NFRAMES * 16;
    localparam int unsigned WAW = $clog2(NW);
    localparam int unsigned FRW = $clog2(NFRAMES);

    localparam logic [15:0]    HDR_LAST   = 16'(HDR_LEN - 1);
    localparam logic [WAW-1:0] WORD_LAST  = WAW'(NW - 1);
    localparam logic [FRW-1:0] FRAME_LAST = FRW'(NFRAMES - 1);

    typedef enum logic [1:0] {PG_FREE, PG_FILLING, PG_FULL, PG_PLAYING} pgState_t;
    typedef enum logic [1:0] {RX_IDLE, RX_HDR, RX_PAY, RX_TAIL} rxState_t;
    typedef enum logic {PB_WAIT, PB_EMIT} pbState_t;

    pgState_t r_pgState [2];
    logic     r_lastCommit;

    rxState_t       r_rxState, w_rxNext;
    logic           r_rxPage;
    logic [15:0]    r_byteCnt;
    logic [7:0]     r_typeHi;
    logic [WAW-1:0] r_wordAddr;
    logic [7:0]     r_lowByte;
    logic           r_haveLow;

    logic w_rxOwn, w_p0Free, w_p1Free, w_alloc, w_allocPage;
    logic w_rxRelease, w_commit, w_dropRx, w_wrEn;

    pbState_t       r_pbState, w_pbNext;
    logic [3:0]     r_chan;
    logic [FRW-1:0] r_frame;
    logic           r_pbPage;
    logic           r_pbReal;
    logic           r_primed;

    logic w_full0, w_full1, w_anyPlay, w_playPage, w_promPage, w_promote;
    logic w_start, w_startReal, w_startPage, w_pbRelease;

    logic [15:0] r_mem [2][NW];
    logic [15:0] r_rdData;
    logic        r_pcmValid, r_dataGate, r_urPend, r_underrun, r_drop;
    logic [3:0]  r_pcmChan;

    // A page held by the RX side counts as free on rx_sof, because the
    // packet filling it is being abandoned in that same cycle.
    assign w_rxOwn     = (r_rxState != RX_IDLE);
    assign w_p0Free    = (r_pgState[0] == PG_FREE) || (w_rxOwn && !r_rxPage);
    assign w_p1Free    = (r_pgState[1] == PG_FREE) || (w_rxOwn &&  r_rxPage);
    assign w_allocPage = !w_p0Free;
    assign w_wrEn      = (r_rxState == RX_PAY) && rx_valid && r_haveLow && !rx_sof && !rx_eof;

    // RX next-state logic and page-level events. rx_sof overrides
    // everything, rx_eof comes next, plain bytes last.
    always_comb begin
        w_rxNext    = r_rxState;
        w_alloc     = 1'b0;
        w_rxRelease = 1'b0;
        w_commit    = 1'b0;
        w_dropRx    = 1'b0;
        if (rx_sof) begin
            w_rxRelease = w_rxOwn;
            if (w_p0Free || w_p1Free) begin
                w_alloc  = 1'b1;
                w_rxNext = RX_HDR;
                if (rx_valid && (HDR_LAST == 16'd0)) begin
                    w_rxNext = RX_PAY;
                end
            end else begin
                w_dropRx = 1'b1;
                w_rxNext = RX_IDLE;
            end
        end else if (rx_eof) begin
            if ((r_rxState == RX_TAIL) && rx_crc_ok) begin
                w_commit = 1'b1;
            end else if (w_rxOwn) begin
                w_rxRelease = 1'b1;
                w_dropRx    = 1'b1;
            end
            w_rxNext = RX_IDLE;
        end else if (rx_valid) begin
            case (r_rxState)
                RX_HDR: begin
                    if (CHECK_TYPE && (r_byteCnt == 16'd13) && ({r_typeHi, rx_data} != ETHERTYPE)) begin
                        w_rxRelease = 1'b1;
                        w_dropRx    = 1'b1;
                        w_rxNext    = RX_IDLE;
                    end else if (r_byteCnt == HDR_LAST) begin
                        w_rxNext = RX_PAY;
                    end
                end
                RX_PAY: begin
                    if (r_haveLow && (r_wordAddr == WORD_LAST)) begin
                        w_rxNext = RX_TAIL;
                    end
                end
                default: ;
            endcase
        end
    end

    // RX state register and byte/word datapath. A byte arriving together
    // with rx_sof is header byte 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rxState  <= RX_IDLE;
            r_rxPage   <= 1'b0;
            r_byteCnt  <= '0;
            r_typeHi   <= '0;
            r_wordAddr <= '0;
            r_lowByte  <= '0;
            r_haveLow  <= 1'b0;
        end else begin
            r_rxState <= w_rxNext;
            if (rx_sof) begin
                r_rxPage   <= w_allocPage;
                r_byteCnt  <= rx_valid ? 16'd1 : 16'd0;
                r_wordAddr <= '0;
                r_haveLow  <= 1'b0;
            end else if (rx_valid && (r_rxState == RX_HDR)) begin
                if (r_byteCnt == 16'd12) begin
                    r_typeHi <= rx_data;
                end
                r_byteCnt <= r_byteCnt + 16'd1;
            end else if (rx_valid && (r_rxState == RX_PAY)) begin
                if (r_haveLow) begin
                    r_wordAddr <= r_wordAddr + WAW'(1);
                end else begin
                    r_lowByte <= rx_data;
                end
                r_haveLow <= !r_haveLow;
            end
        end
    end

    assign w_full0    = (r_pgState[0] == PG_FULL);
    assign w_full1    = (r_pgState[1] == PG_FULL);
    assign w_anyPlay  = (r_pgState[0] == PG_PLAYING) || (r_pgState[1] == PG_PLAYING);
    assign w_playPage = (r_pgState[1] == PG_PLAYING);
    // With both pages full, the one not committed most recently is older.
    assign w_promPage = (w_full0 && w_full1) ? !r_lastCommit : w_full1;
    assign w_promote  = (r_pbState == PB_WAIT) && !w_anyPlay && (w_full0 || w_full1);

    assign w_start     = (r_pbState == PB_WAIT) && au_stb_pcm;
    assign w_startReal = w_anyPlay || w_full0 || w_full1;
    assign w_startPage = w_anyPlay ? w_playPage : w_promPage;
    assign w_pbRelease = (r_pbState == PB_EMIT) && (r_chan == 4'hF) && r_pbReal && (r_frame == FRAME_LAST);

    // Playback next-state: one strobe starts a 16-cycle emit burst.
    always_comb begin
        w_pbNext = r_pbState;
        if (w_start) begin
            w_pbNext = PB_EMIT;
        end else if ((r_pbState == PB_EMIT) && (r_chan == 4'hF)) begin
            w_pbNext = PB_WAIT;
        end
    end

    // Playback state register, channel/frame counters and underrun arming.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pbState <= PB_WAIT;
            r_chan    <= '0;
            r_frame   <= '0;
            r_pbPage  <= 1'b0;
            r_pbReal  <= 1'b0;
            r_primed  <= 1'b0;
            r_urPend  <= 1'b0;
        end else begin
            r_pbState <= w_pbNext;
            r_urPend  <= w_start && !w_startReal && r_primed;
            if (w_promote) begin
                r_frame <= '0;
            end
            if (w_start) begin
                r_chan   <= '0;
                r_pbPage <= w_startPage;
                r_pbReal <= w_startReal;
                if (w_startReal) begin
                    r_primed <= 1'b1;
                end
            end else if (r_pbState == PB_EMIT) begin
                r_chan <= r_chan + 4'd1;
                if ((r_chan == 4'hF) && r_pbReal) begin
                    r_frame <= (r_frame == FRAME_LAST) ? '0 : r_frame + FRW'(1);
                end
            end
        end
    end

    // Page ownership. RX only touches FREE/FILLING pages and playback only
    // FULL/PLAYING ones, so simultaneous events always land on different
    // pages; an abort and re-allocation of the same page ends as FILLING.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pgState[0] <= PG_FREE;
            r_pgState[1] <= PG_FREE;
            r_lastCommit <= 1'b0;
        end else begin
            for (int p = 0; p < 2; p++) begin
                if (w_pbRelease && (r_pbPage == 1'(p))) r_pgState[p] <= PG_FREE;
                if (w_promote && (w_promPage == 1'(p))) r_pgState[p] <= PG_PLAYING;
                if (w_rxRelease && (r_rxPage == 1'(p))) r_pgState[p] <= PG_FREE;
                if (w_alloc && (w_allocPage == 1'(p)))  r_pgState[p] <= PG_FILLING;
                if (w_commit && (r_rxPage == 1'(p)))    r_pgState[p] <= PG_FULL;
            end
            if (w_commit) begin
                r_lastCommit <= r_rxPage;
            end
        end
    end

    // Sample storage; write and read never address the same page.
    always_ff @(posedge clk) begin
        if (w_wrEn) begin
            r_mem[r_rxPage][r_wordAddr] <= {rx_data, r_lowByte};
        end
        r_rdData <= r_mem[r_pbPage][{r_frame, r_chan}];
    end

    // Output stage, aligned with the one-cycle memory read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pcmValid <= 1'b0;
            r_pcmChan  <= '0;
            r_dataGate <= 1'b0;
            r_underrun <= 1'b0;
            r_drop     <= 1'b0;
        end else begin
            r_pcmValid <= (r_pbState == PB_EMIT);
            r_pcmChan  <= (r_pbState == PB_EMIT) ? r_chan : 4'd0;
            r_dataGate <= (r_pbState == PB_EMIT) && r_pbReal;
            r_underrun <= r_urPend;
            r_drop     <= w_dropRx;
        end
    end

    assign pcm_valid = r_pcmValid;
    assign pcm_chan  = r_pcmChan;
    assign pcm_data  = r_dataGate ? r_rdData : 16'd0;
    assign drop      = r_drop;
    assign underrun  = r_underrun;

endmodule

// File: tb/tb_pcm_receiver.sv
// ---------------------------------------------------------------------------
// tb_pcm_receiver: drives randomised packets into pcm_receiver and checks the
// played-out samples, drop and underrun pulses against a packet-level model
// (a FIFO of committed sample words, at most two packets held).
// ---------------------------------------------------------------------------
module tb_pcm_receiver;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rx_sof, rx_valid, rx_eof, rx_crc_ok, au_stb_pcm;
    logic [7:0]  rx_data;
    logic        pcm_valid, drop, underrun;
    logic [3:0]  pcm_chan;
    logic [15:0] pcm_data;

    int checks  = 0;
    int errors  = 0;
    int dropCnt = 0;
    int urCnt   = 0;
    int expDrop = 0;
    int expUr   = 0;
    bit primed  = 1'b0;

    logic [15:0] wordQ [$];
    logic [15:0] pktWords [256];

    pcm_receiver dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_sof     (rx_sof),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .rx_eof     (rx_eof),
        .rx_crc_ok  (rx_crc_ok),
        .au_stb_pcm (au_stb_pcm),
        .pcm_valid  (pcm_valid),
        .pcm_chan   (pcm_chan),
        .pcm_data   (pcm_data),
        .drop       (drop),
        .underrun   (underrun)
    );

    always #5 clk = ~clk;

    // Pulse counters, sampled mid-cycle.
    always @(negedge clk) begin
        if (drop === 1'b1) dropCnt++;
        if (underrun === 1'b1) urCnt++;
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic checkCounts(input string tag);
        @(posedge clk);
        checkOutput({tag, "_drops"}, 32'(dropCnt), 32'(expDrop));
        checkOutput({tag, "_underruns"}, 32'(urCnt), 32'(expUr));
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, "_valid"}, 32'(pcm_valid), 32'd0);
        checkOutput({tag, "_chan"}, 32'(pcm_chan), 32'd0);
        checkOutput({tag, "_data"}, 32'(pcm_data), 32'd0);
        checkOutput({tag, "_drop"}, 32'(drop), 32'd0);
        checkOutput({tag, "_underrun"}, 32'(underrun), 32'd0);
    endtask

    task automatic fillRandom();
        for (int i = 0; i < 256; i++) pktWords[i] = 16'($urandom);
    endtask

    // Sends one frame: header, payload of pktWords (little-endian), padding
    // and FCS, then rx_eof. With payStop >= 0 only that many payload bytes
    // are sent and the frame is left unfinished.
    task automatic applyStimulus(input logic [15:0] etype, input bit crcOk, input int payStop);
        logic [7:0] b [$];
        int idx;
        bit accepted;
        for (int i = 0; i < 12; i++) b.push_back(8'($urandom));
        b.push_back(etype[15:8]);
        b.push_back(etype[7:0]);
        for (int i = 0; i < 256; i++) begin
            b.push_back(pktWords[i][7:0]);
            b.push_back(pktWords[i][15:8]);
        end
        if (payStop >= 0) begin
            while (b.size() > 14 + payStop) void'(b.pop_back());
        end else begin
            repeat ($urandom_range(0, 3) + 4) b.push_back(8'($urandom));
        end

        accepted = ((wordQ.size() + 255) / 256) < 2;
        if (!accepted) expDrop++;
        else if (etype != 16'h88B5) expDrop++;
        else if (payStop < 0) begin
            if (crcOk) begin
                for (int i = 0; i < 256; i++) wordQ.push_back(pktWords[i]);
            end else begin
                expDrop++;
            end
        end

        idx = 0;
        @(negedge clk);
        rx_sof = 1'b1;
        rx_valid = 1'b0;
        if ($urandom_range(0, 1) == 1) begin
            rx_valid = 1'b1;
            rx_data = b[0];
            idx = 1;
        end
        while (idx < b.size()) begin
            @(negedge clk);
            rx_sof = 1'b0;
            if ($urandom_range(0, 3) == 0) begin
                rx_valid = 1'b0;
            end else begin
                rx_valid = 1'b1;
                rx_data = b[idx];
                idx++;
            end
        end
        @(negedge clk);
        rx_sof = 1'b0;
        rx_valid = 1'b0;
        if (payStop < 0) begin
            rx_eof = 1'b1;
            rx_crc_ok = crcOk;
            @(negedge clk);
            rx_eof = 1'b0;
            rx_crc_ok = 1'b0;
        end
        repeat (2) @(negedge clk);
    endtask

    // One strobe; expects 16 samples at N+2..N+17. With poke set, a second
    // strobe is fired mid-burst and must be ignored.
    task automatic strobeAndCheck(input bit poke);
        logic [15:0] expw [16];
        bit hasData;
        bit expUnder;
        hasData  = (wordQ.size() > 0);
        expUnder = !hasData && primed;
        for (int i = 0; i < 16; i++) expw[i] = hasData ? wordQ.pop_front() : 16'd0;
        if (hasData) primed = 1'b1;
        if (expUnder) expUr++;

        @(negedge clk);
        au_stb_pcm = 1'b1;
        @(negedge clk);
        au_stb_pcm = 1'b0;
        checkOutput("valid_n1", 32'(pcm_valid), 32'd0);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            au_stb_pcm = (poke && (i == 3)) ? 1'b1 : 1'b0;
            checkOutput("valid", 32'(pcm_valid), 32'd1);
            checkOutput("chan", 32'(pcm_chan), 32'(i));
            checkOutput("data", 32'(pcm_data), 32'(expw[i]));
            if (i == 0) checkOutput("underrun_n2", 32'(underrun), 32'(expUnder));
        end
        @(negedge clk);
        au_stb_pcm = 1'b0;
        checkOutput("valid_after", 32'(pcm_valid), 32'd0);
        checkOutput("chan_after", 32'(pcm_chan), 32'd0);
        checkOutput("data_after", 32'(pcm_data), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        rx_sof = 1'b0;
        rx_valid = 1'b0;
        rx_data = 8'd0;
        rx_eof = 1'b0;
        rx_crc_ok = 1'b0;
        au_stb_pcm = 1'b0;

        repeat (3) @(negedge clk);
        checkIdleOutputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] strobe with nothing received");
        strobeAndCheck(1'b0);
        checkCounts("empty");

        $display("[TB] wrong ethertype");
        fillRandom();
        applyStimulus(16'h0800, 1'b1, -1);
        checkCounts("etype");
        strobeAndCheck(1'b0);
        checkCounts("etype_play");

        $display("[TB] patterned good packet");
        for (int i = 0; i < 256; i++) pktWords[i] = 16'((i % 16) + 256 * (i / 16));
        applyStimulus(16'h88B5, 1'b1, -1);
        checkCounts("good_rx");
        for (int f = 0; f < 16; f++) strobeAndCheck(f == 2);
        checkCounts("good_play");

        $display("[TB] underrun after playout");
        strobeAndCheck(1'b0);
        checkCounts("underrun");

        $display("[TB] bad crc then good packet");
        fillRandom();
        applyStimulus(16'h88B5, 1'b0, -1);
        checkCounts("badcrc");
        fillRandom();
        applyStimulus(16'h88B5, 1'b1, -1);
        for (int f = 0; f < 16; f++) strobeAndCheck(1'b0);
        checkCounts("reuse");

        $display("[TB] three back-to-back packets");
        repeat (3) begin
            fillRandom();
            applyStimulus(16'h88B5, 1'b1, -1);
        end
        checkCounts("b2b_rx");
        for (int f = 0; f < 32; f++) strobeAndCheck(1'b0);
        checkCounts("b2b_play");

        $display("[TB] aborted packet then good packet");
        fillRandom();
        applyStimulus(16'h88B5, 1'b1, 100);
        fillRandom();
        applyStimulus(16'h88B5, 1'b1, -1);
        checkCounts("abort_rx");
        for (int f = 0; f < 16; f++) strobeAndCheck(1'b0);
        checkCounts("abort_play");

        $display("[TB] reset mid-packet and mid-frame");
        fillRandom();
        applyStimulus(16'h88B5, 1'b1, -1);
        fillRandom();
        applyStimulus(16'h88B5, 1'b1, 100);
        @(negedge clk);
        au_stb_pcm = 1'b1;
        @(negedge clk);
        au_stb_pcm = 1'b0;
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        wordQ.delete();
        primed = 1'b0;
        @(negedge clk);
        checkIdleOutputs("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("post_reset_valid", 32'(pcm_valid), 32'd0);
        end
        strobeAndCheck(1'b0);
        fillRandom();
        applyStimulus(16'h88B5, 1'b1, -1);
        strobeAndCheck(1'b0);
        strobeAndCheck(1'b0);
        checkCounts("final");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
